// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter measuring an asynchronous square wave
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 ovf,
    output logic                 valid,
    output logic [7:0]           LEDS
);

    localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_MAX = '1;
    localparam int unsigned LW = (CNT_WIDTH < 8) ? CNT_WIDTH : 8;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 s1;
    logic                 s2;
    logic                 p;
    logic                 edge_det;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [CNT_WIDTH-1:0] cnt_sum;
    logic                 sticky;
    logic                 sticky_nxt;
    logic                 sat_now;
    logic                 terminal;

    // Synchronizer and history flop reset high so a level held across reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            p  <= 1'b1;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign edge_det = s2 & ~p;
    assign sat_now  = edge_det & (cnt == C_MAX);
    assign cnt_sum  = (edge_det && (cnt != C_MAX)) ? cnt + CNT_WIDTH'(1) : cnt;
    assign terminal = (state == MEASURE) && (timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            cnt    <= cnt_nxt;
            sticky <= sticky_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        cnt_nxt    = cnt;
        sticky_nxt = sticky;
        case (state)
            IDLE: begin
                timer_nxt  = '0;
                cnt_nxt    = '0;
                sticky_nxt = 1'b0;
                if (en) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (terminal) begin
                    timer_nxt  = '0;
                    cnt_nxt    = '0;
                    sticky_nxt = 1'b0;
                end else begin
                    timer_nxt  = timer + TW'(1);
                    cnt_nxt    = cnt_sum;
                    sticky_nxt = sticky | sat_now;
                end
                // Dropping en discards the partial window; a completing one still publishes.
                if (!en) begin
                    state_nxt  = IDLE;
                    timer_nxt  = '0;
                    cnt_nxt    = '0;
                    sticky_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_out <= '0;
            ovf       <= 1'b0;
            valid     <= 1'b0;
            LEDS      <= '0;
        end else begin
            valid <= terminal;
            if (terminal) begin
                count_out <= cnt_sum;
                ovf       <= sticky | sat_now;
            end
            LEDS <= 8'(count_out[LW-1:0]);
        end
    end

endmodule
